ls_queue: RTL
=============

# ls_queue

Parametrised in-order load/store queue between the dispatcher and the LSU. It generalises the fixed LS buffer to configurable depth, tag, data and branch-tag widths, and an arbitrary number of CDB snoop ports. It adds a full/free-count interface, suffix rollback on misprediction, and an optional same-cycle CDB bypass. Entries are allocated at the tail, issued in program order once operands are resolved and non-speculative, and retired at the head on LSU completion.

## Interface
- DEPTH, 8, entry count; power of two, ≥2
- DATA_W, 32, operand/imm width
- TAG_W, 5, rename tag width
- TAG_FREE, 0, tag value meaning "operand valid"
- OP_W, 6, opcode width
- BTAG_W, 4, branch-tag mask width
- CDB_PORTS, 2, number of writeback snoop ports
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global stall; low freezes all state
- cdb_en  in  CDB_PORTS  per-port broadcast valid
- cdb_tag  in  CDB_PORTS*TAG_W  packed tags, port p at [p*TAG_W +: TAG_W]
- cdb_data  in  CDB_PORTS*DATA_W  packed data
- alloc_en  in  1  allocate one entry
- alloc_op, alloc_imm, alloc_tag_w  in  OP_W/DATA_W/TAG_W  opcode, offset, destination tag
- alloc_opnd_o, alloc_opnd_t  in  DATA_W  base / store-data values
- alloc_tag_o, alloc_tag_t  in  TAG_W  pending tags (TAG_FREE = value valid)
- alloc_btag  in  BTAG_W  unresolved-branch mask
- alloc_ready  out  1  queue not full
- free_slots  out  $clog2(DEPTH+1)  empty entry count
- lsu_ready  in  1  LSU can accept an op
- lsu_done  in  1  LSU finished the head op
- issue_valid  out  1  registered one-cycle issue strobe
- issue_op, issue_opnd_o, issue_opnd_t, issue_imm, issue_tag_w  out  —  registered issue payload
- br_free_en  in  1  branch resolved correct
- br_free_idx  in  $clog2(BTAG_W)  resolved branch bit
- br_mispredict  in  1  branch at br_free_idx mispredicted

## Operation
- Pointers: head (oldest unretired), iss (next to issue), tail (next free); count in [0, DEPTH]. All wrap modulo DEPTH. Invariant: head ≤ iss ≤ tail in queue order.
- Alloc: alloc_en && count<DEPTH writes the entry at tail and advances tail. Alloc while full is ignored. alloc_btag is masked by the same-cycle br_free_en bit clear.
- Snoop: every valid pending operand compares against all CDB ports. On a match it captures the data and its tag becomes TAG_FREE. If multiple ports match, the lowest port index wins. Snoop also applies to the entry being allocated in that cycle.
- Ready: entry[iss] is ready when iss≠tail, both tags equal TAG_FREE, and btag==0.
- Issue: lsu_ready && ready(iss) registers the payload, pulses issue_valid, and advances iss. Otherwise issue_valid=0 and the payload is zeroed.
- Retire: lsu_done advances head. lsu_done with head==iss is a protocol violation and is ignored.
- br_free_en && !br_mispredict clears bit br_free_idx in every live entry.
- br_mispredict sets tail to the oldest live entry with bit br_free_idx set, or leaves tail unchanged if none. Branch masks are assigned in program order, so discarded entries always form a suffix and never include issued entries.
- Simultaneous mispredict and alloc: alloc is dropped. Mispredict wins over br_free. Alloc, issue and retire in the same cycle are all permitted; count = count + alloc − retire − discarded.

## Timing
- Reset values: head=iss=tail=0, count=0, all tags TAG_FREE, all btags 0, issue_valid=0, payload 0, alloc_ready=1, free_slots=DEPTH.
- alloc_ready = (count≠DEPTH); free_slots = DEPTH−count. Both are combinational from registered count.
- Minimum latency: alloc at edge N with operands ready → issue_valid high after edge N+1.
- rdy=0: no register changes and outputs hold. Asserting rst at any point returns all state to reset values.

## Configuration
- LSQ_CDB_BYPASS_EN defined: the ready/issue evaluation for entry[iss] uses CDB data arriving in the same cycle. A CDB match in cycle k lets issue_valid rise after edge k+1.
- LSQ_CDB_BYPASS_EN undefined: only captured state is used. The same case issues after edge k+2.

## Test plan
- Fill to DEPTH=8 with ready ops, lsu_ready=0 → alloc_ready=0, free_slots=0. A 9th alloc is ignored, and the first issue carries entry 0's tag_w.
- Entry with tag_o=3 pending; cdb_en=2'b10, cdb_tag port1=3, data=0xDEAD → issue_opnd_o=0xDEAD. Issue occurs 1 cycle after the broadcast with bypass, 2 cycles without.
- Entries A(btag 0), B(btag 0b0010), C(btag 0b0010); br_mispredict idx1 → tail rolls back to B, free_slots rises by 2, only A issues.
- Entry with btag 0b0100; br_free_en idx2 → entry issues the next cycle. A simultaneous alloc with btag 0b0100 is stored as 0.
- Wrap-around: 20 alloc/issue/done sequences with DEPTH=8 → in-order issue_tag_w sequence, count never exceeds 8.
- Assert rst with 5 entries live and issue_valid high → all outputs reach reset values immediately, free_slots=8.

Source files
------------

// File: rtl/ls_queue.sv
// In-order load/store queue: tail allocation with CDB snoop, in-order issue, head retire, branch rollback.
// Optional LSQ_CDB_BYPASS_EN: issue readiness for the entry at iss also uses same-cycle CDB data.
module ls_queue #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 5,
  parameter int TAG_FREE  = 0,
  parameter int OP_W      = 6,
  parameter int BTAG_W    = 4,
  parameter int CDB_PORTS = 2,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int BI_W     = (BTAG_W > 1) ? $clog2(BTAG_W) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [CDB_PORTS-1:0]        cdb_en,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  input  logic                        alloc_en,
  input  logic [OP_W-1:0]             alloc_op,
  input  logic [DATA_W-1:0]           alloc_imm,
  input  logic [TAG_W-1:0]            alloc_tag_w,
  input  logic [DATA_W-1:0]           alloc_opnd_o,
  input  logic [DATA_W-1:0]           alloc_opnd_t,
  input  logic [TAG_W-1:0]            alloc_tag_o,
  input  logic [TAG_W-1:0]            alloc_tag_t,
  input  logic [BTAG_W-1:0]           alloc_btag,
  output logic                        alloc_ready,
  output logic [CNT_W-1:0]            free_slots,
  input  logic                        lsu_ready,
  input  logic                        lsu_done,
  output logic                        issue_valid,
  output logic [OP_W-1:0]             issue_op,
  output logic [DATA_W-1:0]           issue_opnd_o,
  output logic [DATA_W-1:0]           issue_opnd_t,
  output logic [DATA_W-1:0]           issue_imm,
  output logic [TAG_W-1:0]            issue_tag_w,
  input  logic                        br_free_en,
  input  logic [BI_W-1:0]             br_free_idx,
  input  logic                        br_mispredict
);

  localparam logic [TAG_W-1:0] TFREE   = TAG_W'(TAG_FREE);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [TAG_W-1:0]  tagw_q [DEPTH];
  logic [DATA_W-1:0] opo_q  [DEPTH], opo_d  [DEPTH];
  logic [DATA_W-1:0] opt_q  [DEPTH], opt_d  [DEPTH];
  logic [TAG_W-1:0]  tgo_q  [DEPTH], tgo_d  [DEPTH];
  logic [TAG_W-1:0]  tgt_q  [DEPTH], tgt_d  [DEPTH];
  logic [BTAG_W-1:0] btag_q [DEPTH], btag_d [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d, iss_q, iss_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d, nissued_q, nissued_d, unissued;

  logic              issue_valid_q;
  logic [OP_W-1:0]   issue_op_q;
  logic [DATA_W-1:0] issue_opnd_o_q, issue_opnd_t_q, issue_imm_q;
  logic [TAG_W-1:0]  issue_tag_w_q;

  logic              br_clr, do_alloc, do_retire, do_issue;
  logic [BTAG_W-1:0] clr_mask;
  logic              rdy_o, rdy_t, mp_found;
  logic [DATA_W-1:0] iss_opo, iss_opt;
  logic [CNT_W-1:0]  mp_keep;

  // Lowest-numbered matching port wins, so scan from the top and let lower ports overwrite.
  function automatic void snoop(input  logic [TAG_W-1:0]            t,
                                input  logic [CDB_PORTS-1:0]        en,
                                input  logic [CDB_PORTS*TAG_W-1:0]  tags,
                                input  logic [CDB_PORTS*DATA_W-1:0] data,
                                output logic                        hit,
                                output logic [DATA_W-1:0]           val);
    hit = 1'b0;
    val = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (en[p] && (t != TFREE) && (tags[p*TAG_W +: TAG_W] == t)) begin
        hit = 1'b1;
        val = data[p*DATA_W +: DATA_W];
      end
    end
  endfunction

  assign br_clr      = br_free_en && !br_mispredict;
  assign clr_mask    = br_clr ? (BTAG_W'(1) << br_free_idx) : '0;
  assign do_alloc    = alloc_en && (count_q != DEPTH_C) && !br_mispredict;
  assign do_retire   = lsu_done && (nissued_q != '0);
  assign unissued    = count_q - nissued_q;
  assign alloc_ready = (count_q != DEPTH_C);
  assign free_slots  = DEPTH_C - count_q;

  always_comb begin
    logic              hit;
    logic [DATA_W-1:0] val;
    hit = 1'b0;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      opo_d[i]  = opo_q[i];
      opt_d[i]  = opt_q[i];
      tgo_d[i]  = tgo_q[i];
      tgt_d[i]  = tgt_q[i];
      btag_d[i] = btag_q[i] & ~clr_mask;
      snoop(tgo_q[i], cdb_en, cdb_tag, cdb_data, hit, val);
      if (hit) begin
        tgo_d[i] = TFREE;
        opo_d[i] = val;
      end
      snoop(tgt_q[i], cdb_en, cdb_tag, cdb_data, hit, val);
      if (hit) begin
        tgt_d[i] = TFREE;
        opt_d[i] = val;
      end
      if (do_alloc && (tail_q == PTR_W'(i))) begin
        btag_d[i] = alloc_btag & ~clr_mask;
        tgo_d[i]  = alloc_tag_o;
        opo_d[i]  = alloc_opnd_o;
        tgt_d[i]  = alloc_tag_t;
        opt_d[i]  = alloc_opnd_t;
        snoop(alloc_tag_o, cdb_en, cdb_tag, cdb_data, hit, val);
        if (hit) begin
          tgo_d[i] = TFREE;
          opo_d[i] = val;
        end
        snoop(alloc_tag_t, cdb_en, cdb_tag, cdb_data, hit, val);
        if (hit) begin
          tgt_d[i] = TFREE;
          opt_d[i] = val;
        end
      end
    end
  end

  always_comb begin
`ifdef LSQ_CDB_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_val;
`endif
    iss_opo = opo_q[iss_q];
    iss_opt = opt_q[iss_q];
    rdy_o   = (tgo_q[iss_q] == TFREE);
    rdy_t   = (tgt_q[iss_q] == TFREE);
`ifdef LSQ_CDB_BYPASS_EN
    snoop(tgo_q[iss_q], cdb_en, cdb_tag, cdb_data, byp_hit, byp_val);
    if (byp_hit) begin
      rdy_o   = 1'b1;
      iss_opo = byp_val;
    end
    snoop(tgt_q[iss_q], cdb_en, cdb_tag, cdb_data, byp_hit, byp_val);
    if (byp_hit) begin
      rdy_t   = 1'b1;
      iss_opt = byp_val;
    end
`endif
    do_issue = lsu_ready && (unissued != '0) && rdy_o && rdy_t && (btag_q[iss_q] == '0);
  end

  // Oldest live entry tagged with the mispredicted branch becomes the new tail.
  always_comb begin
    mp_found = 1'b0;
    mp_keep  = count_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (!mp_found && (CNT_W'(k) < count_q) && btag_q[head_q + PTR_W'(k)][br_free_idx]) begin
        mp_found = 1'b1;
        mp_keep  = CNT_W'(k);
      end
    end
  end

  always_comb begin
    head_d    = head_q + PTR_W'(do_retire);
    iss_d     = iss_q + PTR_W'(do_issue);
    tail_d    = tail_q + PTR_W'(do_alloc);
    count_d   = count_q + CNT_W'(do_alloc) - CNT_W'(do_retire);
    nissued_d = nissued_q + CNT_W'(do_issue) - CNT_W'(do_retire);
    if (br_mispredict && mp_found) begin
      tail_d  = head_q + PTR_W'(mp_keep);
      count_d = mp_keep - CNT_W'(do_retire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      iss_q          <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      nissued_q      <= '0;
      issue_valid_q  <= 1'b0;
      issue_op_q     <= '0;
      issue_opnd_o_q <= '0;
      issue_opnd_t_q <= '0;
      issue_imm_q    <= '0;
      issue_tag_w_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tgo_q[i]  <= TFREE;
        tgt_q[i]  <= TFREE;
        btag_q[i] <= '0;
      end
    end else if (rdy) begin
      head_q         <= head_d;
      iss_q          <= iss_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      nissued_q      <= nissued_d;
      tgo_q          <= tgo_d;
      tgt_q          <= tgt_d;
      btag_q         <= btag_d;
      issue_valid_q  <= do_issue;
      issue_op_q     <= do_issue ? op_q[iss_q]   : '0;
      issue_opnd_o_q <= do_issue ? iss_opo       : '0;
      issue_opnd_t_q <= do_issue ? iss_opt       : '0;
      issue_imm_q    <= do_issue ? imm_q[iss_q]  : '0;
      issue_tag_w_q  <= do_issue ? tagw_q[iss_q] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      opo_q <= opo_d;
      opt_q <= opt_d;
      if (do_alloc) begin
        op_q[tail_q]   <= alloc_op;
        imm_q[tail_q]  <= alloc_imm;
        tagw_q[tail_q] <= alloc_tag_w;
      end
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_op     = issue_op_q;
  assign issue_opnd_o = issue_opnd_o_q;
  assign issue_opnd_t = issue_opnd_t_q;
  assign issue_imm    = issue_imm_q;
  assign issue_tag_w  = issue_tag_w_q;

endmodule
